// File: rtl/clock_divider_prog_if.sv
// Configuration write channel of clock_divider_prog: a valid/ready handshake
// carrying a target channel and a new divisor.
interface clock_divider_prog_if #(
  parameter int CH_W  = 3,
  parameter int CNT_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan;
  logic [CNT_W-1:0] cfg_div;

  modport master (output cfg_valid, output cfg_chan, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_chan, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clock_divider_prog.sv
// Multi-channel synchronous clock divider with runtime divisors that switch
// only at period boundaries, plus a common sync that phase-aligns all channels.
module clock_divider_prog #(
  parameter int CHANNELS = 5,
  parameter int CNT_W    = 16,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sync,
  clock_divider_prog_if.slave cfg,
  output logic [CHANNELS-1:0] div_out,
  output logic [CHANNELS-1:0] tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] reset_div(input int i);
    if (i + 1 >= CNT_W) return '1;
    return ONE << (i + 1);
  endfunction

  logic [CH_W-1:0]     chan_sel;
  logic [CNT_W-1:0]    d_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    p_q   [CHANNELS];
  logic [CHANNELS-1:0] pend_q;

  logic [CNT_W-1:0]    d_n   [CHANNELS];
  logic [CNT_W-1:0]    cnt_n [CHANNELS];
  logic [CNT_W-1:0]    p_n   [CHANNELS];
  logic [CHANNELS-1:0] pend_n;
  logic [CHANNELS-1:0] div_n;
  logic [CHANNELS-1:0] tick_n;

  assign chan_sel = cfg.cfg_chan;

  // Out-of-range channel numbers match nothing, so they stay ready and are dropped.
  always_comb begin
    cfg.cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(chan_sel) == i) cfg.cfg_ready = ~pend_q[i];
    end
  end

  always_comb begin
    logic             hit;
    logic             apply;
    logic             wrap;
    logic [CNT_W-1:0] half;
    pend_n = '0;
    div_n  = '0;
    tick_n = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hit   = cfg.cfg_valid && (int'(chan_sel) == i) && !pend_q[i];
      wrap  = (d_q[i] <= ONE) || (cnt_q[i] == d_q[i] - ONE);
      apply = pend_q[i] && (sync || wrap);

      d_n[i]    = apply ? p_q[i] : d_q[i];
      p_n[i]    = hit ? cfg.cfg_div : p_q[i];
      pend_n[i] = apply ? 1'b0 : (hit | pend_q[i]);

      if (apply || sync || wrap) cnt_n[i] = '0;
      else                       cnt_n[i] = cnt_q[i] + ONE;

      // Odd divisors get the extra cycle in the high phase.
      half      = d_n[i] - (d_n[i] >> 1);
      div_n[i]  = (d_n[i] != '0) && (cnt_n[i] < half);
      tick_n[i] = (d_n[i] != '0) && (cnt_n[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        d_q[i]   <= reset_div(i);
        cnt_q[i] <= '0;
        p_q[i]   <= '0;
      end
      pend_q  <= '0;
      div_out <= '0;
      tick    <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        d_q[i]   <= d_n[i];
        cnt_q[i] <= cnt_n[i];
        p_q[i]   <= p_n[i];
      end
      pend_q  <= pend_n;
      div_out <= div_n;
      tick    <= tick_n;
    end
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog: default ladder, glitch-free divisor
// changes, handshake stalls, sync alignment and reset with pending updates.
module tb_clock_divider_prog;
  localparam int CHANNELS = 5;
  localparam int CNT_W    = 16;
  localparam int CH_W     = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic                sync;
  logic [CHANNELS-1:0] div_out;
  logic [CHANNELS-1:0] tick;

  int n_checks = 0;
  int n_fail   = 0;

  clock_divider_prog_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg_if ();

  clock_divider_prog #(.CHANNELS(CHANNELS), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .sync    (sync),
    .cfg     (cfg_if.slave),
    .div_out (div_out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    cfg_if.cfg_valid = 1'b0;
    sync  = 1'b0;
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
  endtask

  task automatic write_req(input int chan, input int div);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan  = CH_W'(chan);
    cfg_if.cfg_div   = CNT_W'(div);
    #1;
  endtask

  task automatic ready_of(input int chan, output logic rdy);
    cfg_if.cfg_chan = CH_W'(chan);
    #1;
    rdy = cfg_if.cfg_ready;
  endtask

  // 32 edges from reset release with the default ladder /2../32.
  task automatic check_defaults(input string tag);
    int cnt [CHANNELS];
    int first4;
    for (int i = 0; i < CHANNELS; i++) cnt[i] = 0;
    first4 = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      for (int i = 0; i < CHANNELS; i++) if (tick[i]) cnt[i]++;
      if (tick[4] && first4 == 0) first4 = k;
    end
    check({tag, "_ticks0"}, cnt[0], 16);
    check({tag, "_ticks1"}, cnt[1], 8);
    check({tag, "_ticks2"}, cnt[2], 4);
    check({tag, "_ticks3"}, cnt[3], 2);
    check({tag, "_ticks4"}, cnt[4], 1);
    check({tag, "_first_tick4"}, first4, 32);
  endtask

  initial begin
    logic       rdy;
    logic [3:0] d0_seq;
    logic [5:0] tv6, dv6;
    logic [9:0] tv10, dv10;
    logic [7:0] tv8, dv8;
    logic [4:0] rdy_all;
    int         tcnt [CHANNELS];
    int         hi4, first4, quiet;

    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_chan  = '0;
    cfg_if.cfg_div   = '0;
    sync  = 1'b0;
    reset = 1'b1;

    // Reset state and default ladder over 64 edges
    steps(2);
    check("reset_div_out", div_out, 0);
    check("reset_tick", tick, 0);
    check("reset_ready", cfg_if.cfg_ready, 1);
    reset = 1'b0;
    for (int i = 0; i < CHANNELS; i++) tcnt[i] = 0;
    hi4 = 0; first4 = 0; d0_seq = '0;
    for (int k = 1; k <= 64; k++) begin
      step();
      if (k <= 4) d0_seq = {d0_seq[2:0], div_out[0]};
      for (int i = 0; i < CHANNELS; i++) if (tick[i]) tcnt[i]++;
      if (div_out[4]) hi4++;
      if (tick[4] && first4 == 0) first4 = k;
    end
    check("def_div0_seq", d0_seq, 4'b0101);
    check("def_ticks0", tcnt[0], 32);
    check("def_ticks1", tcnt[1], 16);
    check("def_ticks2", tcnt[2], 8);
    check("def_ticks3", tcnt[3], 4);
    check("def_ticks4", tcnt[4], 2);
    check("def_high4", hi4, 32);
    check("def_first_tick4", first4, 32);

    // ch1: /4 -> /3, accepted while cnt=1, applied at the 3->0 wrap
    do_reset();
    step();
    write_req(1, 3);
    check("ch1_ready_idle", cfg_if.cfg_ready, 1);
    step();
    cfg_if.cfg_valid = 1'b0;
    #1;
    check("ch1_ready_pend", cfg_if.cfg_ready, 0);
    step();
    check("ch1_no_early_tick", tick[1], 0);
    tv6 = '0; dv6 = '0;
    for (int j = 0; j < 6; j++) begin
      step();
      tv6 = {tv6[4:0], tick[1]};
      dv6 = {dv6[4:0], div_out[1]};
    end
    check("ch1_div3_tick", tv6, 6'b100100);
    check("ch1_div3_wave", dv6, 6'b110110);
    ready_of(1, rdy);
    check("ch1_ready_after", rdy, 1);

    // ch2: disable at the end of its period, then re-enable with /5
    do_reset();
    write_req(2, 0);
    step();
    cfg_if.cfg_valid = 1'b0;
    steps(6);
    ready_of(2, rdy);
    check("ch2_still_pend", rdy, 0);
    step();
    check("ch2_off_at_wrap", tick[2], 0);
    quiet = 0;
    for (int j = 0; j < 8; j++) begin
      step();
      quiet += int'(tick[2]) + int'(div_out[2]);
    end
    check("ch2_quiet", quiet, 0);
    write_req(2, 5);
    check("ch2_ready_disabled", cfg_if.cfg_ready, 1);
    step();
    cfg_if.cfg_valid = 1'b0;
    check("ch2_accept_edge", tick[2], 0);
    tv10 = '0; dv10 = '0;
    for (int j = 0; j < 10; j++) begin
      step();
      tv10 = {tv10[8:0], tick[2]};
      dv10 = {dv10[8:0], div_out[2]};
    end
    check("ch2_div5_tick", tv10, 10'b1000010000);
    check("ch2_div5_wave", dv10, 10'b1110011100);

    // ch0: back-to-back writes stall until the first one applies
    do_reset();
    write_req(0, 6);
    step();
    write_req(0, 4);
    check("ch0_stall", cfg_if.cfg_ready, 0);
    step();
    check("ch0_first_apply", tick[0], 1);
    check("ch0_ready_again", cfg_if.cfg_ready, 1);
    step();
    cfg_if.cfg_valid = 1'b0;
    #1;
    check("ch0_second_pend", cfg_if.cfg_ready, 0);
    quiet = int'(tick[0]);
    for (int j = 0; j < 4; j++) begin
      step();
      quiet += int'(tick[0]);
    end
    check("ch0_div6_gap", quiet, 0);
    tv8 = '0; dv8 = '0;
    for (int j = 0; j < 8; j++) begin
      step();
      tv8 = {tv8[6:0], tick[0]};
      dv8 = {dv8[6:0], div_out[0]};
    end
    check("ch0_div4_tick", tv8, 8'b10001000);
    check("ch0_div4_wave", dv8, 8'b11001100);

    // Writes to a nonexistent channel are accepted and change nothing
    do_reset();
    write_req(7, 1);
    check("oor_ready", cfg_if.cfg_ready, 1);
    check_defaults("oor");
    cfg_if.cfg_valid = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      ready_of(i, rdy);
      rdy_all[i] = rdy;
    end
    check("oor_no_pend", rdy_all, 5'b11111);

    // sync mid-period with ch3 pending; ch4 written on the sync edge
    do_reset();
    write_req(3, 3);
    step();
    cfg_if.cfg_valid = 1'b0;
    steps(4);
    sync = 1'b1;
    write_req(4, 7);
    step();
    sync = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    check("sync_tick_all", tick, 5'b11111);
    check("sync_div_all", div_out, 5'b11111);
    ready_of(4, rdy);
    check("sync_ch4_pend", rdy, 0);
    tv6 = {5'b0, tick[3]};
    dv6 = {5'b0, div_out[3]};
    for (int j = 1; j <= 5; j++) begin
      step();
      tv6 = {tv6[4:0], tick[3]};
      dv6 = {dv6[4:0], div_out[3]};
      if (j == 1) check("sync_plus1_tick", tick, 5'b00000);
      if (j == 2) check("sync_plus2_tick", tick, 5'b00001);
    end
    check("sync_ch3_tick", tv6, 6'b100100);
    check("sync_ch3_wave", dv6, 6'b110110);
    steps(26);
    check("ch4_old_period_end", tick[4], 0);
    step();
    check("ch4_apply_tick", tick[4], 1);
    steps(7);
    check("ch4_div7_tick", tick[4], 1);

    // Reset with an update pending drops it and restores defaults
    write_req(2, 9);
    step();
    cfg_if.cfg_valid = 1'b0;
    ready_of(2, rdy);
    check("rst_pend_set", rdy, 0);
    reset = 1'b1;
    step();
    check("rst_div_out", div_out, 0);
    check("rst_tick", tick, 0);
    ready_of(2, rdy);
    check("rst_pend_drop", rdy, 1);
    reset = 1'b0;
    check_defaults("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
